// File: rtl/msf_pkg.sv
// Shared types and constants for the MSF one-minute frame sequencer.
// Field positions are A-bit second indices, MSB first.
package msf_pkg;

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_CHECK   = 2'd2
  } state_e;

  localparam int unsigned SEC_LAST = 59;

  // A bits are kept from the year field up to the last marker bit.
  localparam int unsigned A_FIRST = 17;
  // B53 feeds no field or check here, so only B54..B58 are kept.
  localparam int unsigned B_FIRST = 54;
  localparam int unsigned B_LAST  = 58;

  localparam int unsigned YEAR_POS  = 17;
  localparam int unsigned YEAR_W    = 8;
  localparam int unsigned MONTH_POS = 25;
  localparam int unsigned MONTH_W   = 5;
  localparam int unsigned DAY_POS   = 30;
  localparam int unsigned DAY_W     = 6;
  localparam int unsigned WDAY_POS  = 36;
  localparam int unsigned WDAY_W    = 3;
  localparam int unsigned HOUR_POS  = 39;
  localparam int unsigned HOUR_W    = 6;
  localparam int unsigned MIN_POS   = 45;
  localparam int unsigned MIN_W     = 7;
  localparam int unsigned MARK_POS  = 52;
  localparam int unsigned MARK_W    = 8;

  localparam int unsigned PAR_YEAR_SEC = 54;
  localparam int unsigned PAR_DATE_SEC = 55;
  localparam int unsigned PAR_WDAY_SEC = 56;
  localparam int unsigned PAR_TIME_SEC = 57;
  localparam int unsigned BST_SEC      = 58;

  localparam logic [7:0] MARKER = 8'b0111_1110;

  // True when data plus its parity bit hold an odd number of ones.
  function automatic logic odd_parity(input logic [15:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/msf_frame_sequencer.sv
// Collects one minute of MSF A/B bits between minute markers, validates the
// marker and parity groups, and loads the BCD time/date registers on success.
module msf_frame_sequencer #(
  parameter int unsigned SEC_LAST = msf_pkg::SEC_LAST
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       bit_valid_i,
  input  logic       bit_a_i,
  input  logic       bit_b_i,
  input  logic       minute_mark_i,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] weekday_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o,
  output logic       bst_o,
  output logic       time_valid_o,
  output logic       frame_load_o,
  output logic       sync_o,
  output logic       error_o
);
  import msf_pkg::*;

  state_e                   state_q;
  logic [5:0]               sec_cnt_q;
  logic [SEC_LAST:A_FIRST]  a_q;
  logic [B_LAST:B_FIRST]    b_q;
  logic                     chk_pend_q;
  logic                     err_hold_q;

  logic [7:0] year_q;
  logic [4:0] month_q;
  logic [5:0] day_q;
  logic [2:0] weekday_q;
  logic [5:0] hour_q;
  logic [6:0] minute_q;
  logic       bst_q;
  logic       time_valid_q;
  logic       frame_load_q;
  logic       error_q;

  logic [5:0] sec_inc_d;
  logic       at_last_d;
  logic       strobe_err_d;
  logic [7:0] year_d;
  logic [4:0] month_d;
  logic [5:0] day_d;
  logic [2:0] weekday_d;
  logic [5:0] hour_d;
  logic [6:0] minute_d;
  logic [7:0] marker_d;
  logic       frame_ok_d;

  assign sec_inc_d = sec_cnt_q + 6'd1;
  assign at_last_d = (sec_cnt_q == 6'(SEC_LAST));

  // Short frame (early marker) or overlong frame (bit after the last second).
  assign strobe_err_d = (state_q == ST_RECEIVE) &&
                        (minute_mark_i ? !at_last_d : (bit_valid_i && at_last_d));

  always_comb begin
    year_d    = '0;
    month_d   = '0;
    day_d     = '0;
    weekday_d = '0;
    hour_d    = '0;
    minute_d  = '0;
    marker_d  = '0;
    for (int unsigned i = 0; i < YEAR_W; i++)  year_d[YEAR_W-1-i]     = a_q[YEAR_POS+i];
    for (int unsigned i = 0; i < MONTH_W; i++) month_d[MONTH_W-1-i]   = a_q[MONTH_POS+i];
    for (int unsigned i = 0; i < DAY_W; i++)   day_d[DAY_W-1-i]       = a_q[DAY_POS+i];
    for (int unsigned i = 0; i < WDAY_W; i++)  weekday_d[WDAY_W-1-i]  = a_q[WDAY_POS+i];
    for (int unsigned i = 0; i < HOUR_W; i++)  hour_d[HOUR_W-1-i]     = a_q[HOUR_POS+i];
    for (int unsigned i = 0; i < MIN_W; i++)   minute_d[MIN_W-1-i]    = a_q[MIN_POS+i];
    for (int unsigned i = 0; i < MARK_W; i++)  marker_d[MARK_W-1-i]   = a_q[MARK_POS+i];
  end

  assign frame_ok_d = (marker_d == MARKER) &&
                      odd_parity(16'({year_d, b_q[PAR_YEAR_SEC]})) &&
                      odd_parity(16'({month_d, day_d, b_q[PAR_DATE_SEC]})) &&
                      odd_parity(16'({weekday_d, b_q[PAR_WDAY_SEC]})) &&
                      odd_parity(16'({hour_d, minute_d, b_q[PAR_TIME_SEC]}));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= ST_HUNT;
      sec_cnt_q    <= '0;
      a_q          <= '0;
      b_q          <= '0;
      chk_pend_q   <= 1'b0;
      err_hold_q   <= 1'b0;
      year_q       <= '0;
      month_q      <= '0;
      day_q        <= '0;
      weekday_q    <= '0;
      hour_q       <= '0;
      minute_q     <= '0;
      bst_q        <= 1'b0;
      time_valid_q <= 1'b0;
      frame_load_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      chk_pend_q   <= 1'b0;
      frame_load_q <= 1'b0;

      // The verdict is taken the cycle after CHECK; only seconds >= 17 are
      // stored, so a strobe accepted meanwhile cannot disturb the frame.
      if (chk_pend_q && frame_ok_d) begin
        year_q       <= year_d;
        month_q      <= month_d;
        day_q        <= day_d;
        weekday_q    <= weekday_d;
        hour_q       <= hour_d;
        minute_q     <= minute_d;
        bst_q        <= b_q[BST_SEC];
        time_valid_q <= 1'b1;
        frame_load_q <= 1'b1;
        error_q      <= 1'b0;
        // A coincident strobe error is deferred so the pulses never overlap.
        err_hold_q   <= strobe_err_d;
      end else begin
        error_q    <= err_hold_q | strobe_err_d | chk_pend_q;
        err_hold_q <= 1'b0;
      end

      case (state_q)
        ST_HUNT: begin
          if (minute_mark_i) begin
            state_q   <= ST_RECEIVE;
            sec_cnt_q <= '0;
          end
        end
        ST_RECEIVE: begin
          if (minute_mark_i) begin
            sec_cnt_q <= '0;
            if (at_last_d) state_q <= ST_CHECK;
          end else if (bit_valid_i) begin
            if (at_last_d) begin
              state_q   <= ST_HUNT;
              sec_cnt_q <= '0;
            end else begin
              sec_cnt_q <= sec_inc_d;
              for (int unsigned i = A_FIRST; i <= SEC_LAST; i++)
                if (sec_inc_d == 6'(i)) a_q[i] <= bit_a_i;
              for (int unsigned i = B_FIRST; i <= B_LAST; i++)
                if (sec_inc_d == 6'(i)) b_q[i] <= bit_b_i;
            end
          end
        end
        ST_CHECK: begin
          state_q    <= ST_RECEIVE;
          sec_cnt_q  <= '0;
          chk_pend_q <= 1'b1;
        end
        default: begin
          state_q   <= ST_HUNT;
          sec_cnt_q <= '0;
        end
      endcase
    end
  end

  assign year_o       = year_q;
  assign month_o      = month_q;
  assign day_o        = day_q;
  assign weekday_o    = weekday_q;
  assign hour_o       = hour_q;
  assign minute_o     = minute_q;
  assign bst_o        = bst_q;
  assign time_valid_o = time_valid_q;
  assign frame_load_o = frame_load_q;
  assign error_o      = error_q;
  assign sync_o       = (state_q != ST_HUNT);

endmodule

// File: tb/tb_msf_frame_sequencer.sv
// Self-checking bench for msf_frame_sequencer: frames are built as plain bit
// arrays, and expected time/validity are derived from them by counting.
module tb_msf_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst_ni = 1'b0;
  logic       bit_valid_i = 1'b0;
  logic       bit_a_i = 1'b0;
  logic       bit_b_i = 1'b0;
  logic       minute_mark_i = 1'b0;
  logic [7:0] year_o;
  logic [4:0] month_o;
  logic [5:0] day_o;
  logic [2:0] weekday_o;
  logic [5:0] hour_o;
  logic [6:0] minute_o;
  logic       bst_o, time_valid_o, frame_load_o, sync_o, error_o;

  msf_frame_sequencer #(.SEC_LAST(59)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .bit_valid_i(bit_valid_i), .bit_a_i(bit_a_i),
    .bit_b_i(bit_b_i), .minute_mark_i(minute_mark_i), .year_o(year_o),
    .month_o(month_o), .day_o(day_o), .weekday_o(weekday_o), .hour_o(hour_o),
    .minute_o(minute_o), .bst_o(bst_o), .time_valid_o(time_valid_o),
    .frame_load_o(frame_load_o), .sync_o(sync_o), .error_o(error_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  bit fa[60];
  bit fb[60];

  // Expected display state: {year,month,day,weekday,hour,minute,bst,time_valid}
  logic [36:0] exp_disp = '0;

  function automatic logic [36:0] got_disp();
    return {year_o, month_o, day_o, weekday_o, hour_o, minute_o, bst_o, time_valid_o};
  endfunction

  function automatic int field(int pos, int w);
    int v = 0;
    for (int i = 0; i < w; i++) v = v * 2 + int'(fa[pos+i]);
    return v;
  endfunction

  function automatic int ones(int pos, int w);
    int c = 0;
    for (int i = 0; i < w; i++) c += int'(fa[pos+i]);
    return c;
  endfunction

  function automatic bit model_valid();
    int pattern[8] = '{0, 1, 1, 1, 1, 1, 1, 0};
    bit ok = 1'b1;
    for (int i = 0; i < 8; i++) if (int'(fa[52+i]) != pattern[i]) ok = 1'b0;
    if ((ones(17, 8) + int'(fb[54])) % 2 != 1) ok = 1'b0;
    if ((ones(25, 11) + int'(fb[55])) % 2 != 1) ok = 1'b0;
    if ((ones(36, 3) + int'(fb[56])) % 2 != 1) ok = 1'b0;
    if ((ones(39, 13) + int'(fb[57])) % 2 != 1) ok = 1'b0;
    return ok;
  endfunction

  function automatic int to_bcd(int n);
    return (n / 10) * 16 + (n % 10);
  endfunction

  task automatic put_field(int pos, int w, int val);
    for (int i = 0; i < w; i++) fa[pos+i] = bit'((val >> (w - 1 - i)) & 1);
  endtask

  task automatic build_frame(int yr, int mo, int dy, int wd, int hr, int mi, bit bst);
    for (int s = 0; s < 60; s++) begin
      fa[s] = bit'($urandom_range(0, 1));
      fb[s] = bit'($urandom_range(0, 1));
    end
    put_field(17, 8, yr); put_field(25, 5, mo); put_field(30, 6, dy);
    put_field(36, 3, wd); put_field(39, 6, hr); put_field(45, 7, mi);
    put_field(52, 8, 8'h7E);
    fb[54] = (ones(17, 8) % 2) == 0;
    fb[55] = (ones(25, 11) % 2) == 0;
    fb[56] = (ones(36, 3) % 2) == 0;
    fb[57] = (ones(39, 13) % 2) == 0;
    fb[58] = bst;
    fb[59] = 1'b0;
  endtask

  task automatic build_random();
    build_frame(to_bcd($urandom_range(0, 99)), to_bcd($urandom_range(1, 12)),
                to_bcd($urandom_range(1, 31)), $urandom_range(0, 6),
                to_bcd($urandom_range(0, 23)), to_bcd($urandom_range(0, 59)),
                bit'($urandom_range(0, 1)));
  endtask

  task automatic strobe(input logic m, input logic v, input logic a, input logic b);
    minute_mark_i = m; bit_valid_i = v; bit_a_i = a; bit_b_i = b;
    @(posedge clk); #1;
    minute_mark_i = 1'b0; bit_valid_i = 1'b0; bit_a_i = 1'b0; bit_b_i = 1'b0;
  endtask

  task automatic send_bits(int first, int last, int maxgap, output int errs);
    errs = 0;
    for (int s = first; s <= last; s++) begin
      repeat ($urandom_range(0, maxgap)) begin
        @(posedge clk); #1;
        if (error_o) errs++;
      end
      strobe(1'b0, 1'b1, fa[s], fb[s]);
      if (error_o) errs++;
    end
  endtask

  // Closes the frame with a marker and checks the 2-cycle verdict.
  task automatic close_frame(string name, bit mark_in_check);
    bit valid = model_valid();
    if (valid)
      exp_disp = {8'(field(17, 8)), 5'(field(25, 5)), 6'(field(30, 6)), 3'(field(36, 3)),
                  6'(field(39, 6)), 7'(field(45, 7)), fb[58], 1'b1};
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({frame_load_o, error_o, sync_o} !== 3'b001)
      $display("FAIL %s_n0: load/err/sync got %b required 001", name, {frame_load_o, error_o, sync_o});
    else n_pass++;
    if (mark_in_check) strobe(1'b1, 1'b0, 1'b0, 1'b0);
    else begin @(posedge clk); #1; end
    n_checks++;
    if ({frame_load_o, error_o} !== 2'b00)
      $display("FAIL %s_n1: load/err got %b required 00", name, {frame_load_o, error_o});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({frame_load_o, error_o, sync_o} !== {valid, !valid, 1'b1})
      $display("FAIL %s_n2: load/err/sync got %b required %b", name,
               {frame_load_o, error_o, sync_o}, {valid, !valid, 1'b1});
    else n_pass++;
    n_checks++;
    if (got_disp() !== exp_disp)
      $display("FAIL %s_disp: got %h required %h", name, got_disp(), exp_disp);
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if ({frame_load_o, error_o} !== 2'b00)
      $display("FAIL %s_n3: load/err got %b required 00", name, {frame_load_o, error_o});
    else n_pass++;
    $display("frame %s valid=%0d disp=%h", name, valid, got_disp());
  endtask

  task automatic test_reset();
    int errs = 0;
    rst_ni = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({got_disp(), frame_load_o, error_o, sync_o} !== 40'd0)
      $display("FAIL reset_outputs: got %h required 0", {got_disp(), frame_load_o, error_o, sync_o});
    else n_pass++;
    rst_ni = 1'b1;
    for (int i = 0; i < 10; i++) begin
      strobe(1'b0, 1'b1, 1'b1, 1'b1);
      if (sync_o || error_o || frame_load_o) errs++;
    end
    n_checks++;
    if (errs !== 0) $display("FAIL hunt_ignores_bits: got %0d bad cycles required 0", errs);
    else n_pass++;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if (sync_o !== 1'b1) $display("FAIL hunt_to_receive: sync got %b required 1", sync_o);
    else n_pass++;
    $display("reset/hunt done sync=%b", sync_o);
  endtask

  task automatic test_valid_frame();
    int errs;
    build_frame(8'h23, 8'h06, 8'h15, 4, 8'h14, 8'h37, 1'b1);
    send_bits(1, 59, 2, errs);
    n_checks++;
    if (errs !== 0) $display("FAIL valid_bits_err: got %0d required 0", errs);
    else n_pass++;
    close_frame("valid", 1'b0);
    n_checks++;
    if (got_disp() !== {8'h23, 5'h06, 6'h15, 3'd4, 6'h14, 7'h37, 1'b1, 1'b1})
      $display("FAIL valid_fixed: got %h required %h", got_disp(),
               {8'h23, 5'h06, 6'h15, 3'd4, 6'h14, 7'h37, 1'b1, 1'b1});
    else n_pass++;
  endtask

  task automatic test_parity_error();
    int errs;
    build_frame(8'h23, 8'h06, 8'h15, 4, 8'h14, 8'h37, 1'b1);
    fb[57] = !fb[57];
    send_bits(1, 59, 1, errs);
    close_frame("b57_flip", 1'b0);
  endtask

  task automatic test_short_frame();
    int errs;
    build_random();
    send_bits(1, 40, 1, errs);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({error_o, frame_load_o, sync_o} !== 3'b101)
      $display("FAIL short_err: err/load/sync got %b required 101", {error_o, frame_load_o, sync_o});
    else n_pass++;
    @(posedge clk); #1;
    n_checks++;
    if (error_o !== 1'b0) $display("FAIL short_pulse_width: err got %b required 0", error_o);
    else n_pass++;
    $display("short frame error seen");
    build_random();
    send_bits(1, 59, 2, errs);
    close_frame("after_short", 1'b0);
  endtask

  task automatic test_overlong_frame();
    int errs;
    build_random();
    send_bits(1, 59, 1, errs);
    strobe(1'b0, 1'b1, 1'b1, 1'b0);
    n_checks++;
    if ({error_o, frame_load_o, sync_o} !== 3'b100)
      $display("FAIL overlong_err: err/load/sync got %b required 100", {error_o, frame_load_o, sync_o});
    else n_pass++;
    @(posedge clk); #1;
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({error_o, sync_o} !== 2'b01)
      $display("FAIL overlong_resync: err/sync got %b required 01", {error_o, sync_o});
    else n_pass++;
    $display("overlong frame error seen, resynced");
    build_random();
    send_bits(1, 59, 1, errs);
    close_frame("after_overlong", 1'b0);
  endtask

  task automatic test_back_to_back();
    int errs;
    build_random();
    send_bits(1, 59, 0, errs);
    n_checks++;
    if (errs !== 0) $display("FAIL b2b_bits_err: got %0d required 0", errs);
    else n_pass++;
    close_frame("b2b_mark_in_check", 1'b1);
  endtask

  task automatic test_random_frames();
    int errs;
    for (int f = 0; f < 8; f++) begin
      build_random();
      case ($urandom_range(0, 5))
        3: fa[$urandom_range(52, 59)] ^= 1'b1;
        4: fb[$urandom_range(54, 57)] ^= 1'b1;
        5: fa[$urandom_range(17, 51)] ^= 1'b1;
        default: ;
      endcase
      send_bits(1, 59, 2, errs);
      close_frame($sformatf("rand%0d", f), 1'b0);
    end
  endtask

  task automatic test_reset_midframe();
    int errs;
    int bad = 0;
    build_random();
    send_bits(1, 30, 1, errs);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    exp_disp = '0;
    n_checks++;
    if ({got_disp(), frame_load_o, error_o, sync_o} !== 40'd0)
      $display("FAIL midframe_reset: got %h required 0", {got_disp(), frame_load_o, error_o, sync_o});
    else n_pass++;
    send_bits(31, 59, 1, errs);
    strobe(1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (frame_load_o || error_o) bad++;
      @(posedge clk); #1;
    end
    n_checks++;
    if ({bad, sync_o, time_valid_o} !== {32'd0, 1'b1, 1'b0})
      $display("FAIL midframe_no_load: bad=%0d sync=%b tv=%b required 0/1/0", bad, sync_o, time_valid_o);
    else n_pass++;
    $display("midframe reset: no load after completion");
  endtask

  initial begin
    test_reset();
    test_valid_frame();
    test_parity_error();
    test_short_frame();
    test_overlong_frame();
    test_back_to_back();
    test_random_frames();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
